k12a_sevenseg_scanner: RTL and testbench

Time-multiplexed scan controller for the k12a two-digit seven-segment decoder pair. Holds NUM_PAIRS bytes of display data, with two hex digits per byte, written by the CPU I/O path. Each scan slot drives one byte's nibbles onto the shared decoder inputs and enables the matching common-anode group. A dead-time gap at the start of every slot suppresses ghosting. Writes are double-buffered and commit only at frame boundaries, so the display never tears mid-frame.

---
 rtl/k12a_sevenseg_scanner.sv | 108 ++++++++++
 tb/tb_k12a_sevenseg_scanner.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/k12a_sevenseg_scanner.sv
// k12a two-digit seven-segment scan controller.
// Double-buffered display bytes commit to the active set on each frame wrap.
module k12a_sevenseg_scanner #(
    parameter int NUM_PAIRS = 2,
    parameter int PRESCALE  = 1000,
    parameter int DEADTIME  = 16,
    localparam int PW = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 write_enable,
    input  logic [PW-1:0]        write_pair,
    input  logic [7:0]           write_data,
    input  logic                 display_enable,
    output logic [3:0]           digit0,
    output logic [3:0]           digit1,
    output logic [NUM_PAIRS-1:0] anode_select,
    output logic                 frame_start
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [CW-1:0] SLOT_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] DEAD      = CW'(DEADTIME);
    localparam logic [PW-1:0] PAIR_LAST = PW'(NUM_PAIRS - 1);
    localparam logic [PW:0]   PAIR_CNT  = (PW + 1)'(NUM_PAIRS);

    logic [CW-1:0]        slot_q, slot_d;
    logic [PW-1:0]        pair_q, pair_d;
    logic [7:0]           shadow_q [NUM_PAIRS];
    logic [7:0]           shadow_d [NUM_PAIRS];
    logic [7:0]           active_q [NUM_PAIRS];
    logic [7:0]           active_d [NUM_PAIRS];
    logic [3:0]           digit0_q, digit0_d;
    logic [3:0]           digit1_q, digit1_d;
    logic [NUM_PAIRS-1:0] anode_q, anode_d;
    logic                 frame_q, frame_d;

    logic wrap;
    logic commit;
    logic wr_ok;

    assign wrap   = display_enable && (slot_q == SLOT_LAST);
    assign commit = wrap && (pair_q == PAIR_LAST);
    assign wr_ok  = write_enable && ({1'b0, write_pair} < PAIR_CNT);

    always_comb begin
        slot_d   = slot_q;
        pair_d   = pair_q;
        shadow_d = shadow_q;
        active_d = active_q;
        frame_d  = 1'b0;
        anode_d  = '0;
        digit0_d = active_q[pair_q][3:0];
        digit1_d = active_q[pair_q][7:4];

        if (display_enable) begin
            slot_d = wrap ? '0 : slot_q + 1'b1;
            if (slot_q >= DEAD) begin
                anode_d[pair_q] = 1'b1;
            end
        end

        if (wrap) begin
            pair_d = (pair_q == PAIR_LAST) ? '0 : pair_q + 1'b1;
        end

        // Commit samples shadow_q, so a same-edge write lands next frame.
        if (commit) begin
            active_d = shadow_q;
            frame_d  = 1'b1;
        end

        if (wr_ok) begin
            shadow_d[write_pair] = write_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot_q   <= '0;
            pair_q   <= '0;
            digit0_q <= '0;
            digit1_q <= '0;
            anode_q  <= '0;
            frame_q  <= 1'b0;
            for (int i = 0; i < NUM_PAIRS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            slot_q   <= slot_d;
            pair_q   <= pair_d;
            digit0_q <= digit0_d;
            digit1_q <= digit1_d;
            anode_q  <= anode_d;
            frame_q  <= frame_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign digit0       = digit0_q;
    assign digit1       = digit1_q;
    assign anode_select = anode_q;
    assign frame_start  = frame_q;

endmodule

// File: tb/tb_k12a_sevenseg_scanner.sv
// Directed checks for k12a_sevenseg_scanner with a short scan period.
// Checkpoint table covers the main frames; hand sequences cover hold and reset.
module tb_k12a_sevenseg_scanner;

    localparam int NP = 2;
    localparam int PS = 8;
    localparam int DT = 2;

    typedef struct {
        int         edge_n;
        logic       we;
        logic       wp;
        logic [7:0] wd;
        logic [1:0] an;
        logic [3:0] d0;
        logic [3:0] d1;
        logic       fs;
    } vec_t;

    logic       clock;
    logic       reset_n;
    logic       write_enable;
    logic [0:0] write_pair;
    logic [7:0] write_data;
    logic       display_enable;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [1:0] anode_select;
    logic       frame_start;

    int   n_vec;
    int   n_bad;
    int   e;
    vec_t vecs[$];

    k12a_sevenseg_scanner #(
        .NUM_PAIRS(NP),
        .PRESCALE (PS),
        .DEADTIME (DT)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .write_enable  (write_enable),
        .write_pair    (write_pair),
        .write_data    (write_data),
        .display_enable(display_enable),
        .digit0        (digit0),
        .digit1        (digit1),
        .anode_select  (anode_select),
        .frame_start   (frame_start)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic add(input int en, input logic we, input logic wp,
                       input logic [7:0] wd, input logic [1:0] an,
                       input logic [3:0] d0, input logic [3:0] d1,
                       input logic fs);
        vec_t v;
        v.edge_n = en; v.we = we; v.wp = wp; v.wd = wd;
        v.an = an; v.d0 = d0; v.d1 = d1; v.fs = fs;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [1:0] an,
                         input logic [3:0] d0, input logic [3:0] d1,
                         input logic fs);
        n_vec++;
        if ({anode_select, digit0, digit1, frame_start} !== {an, d0, d1, fs}) begin
            n_bad++;
            $display("FAIL %s: got an=%b d0=%h d1=%h fs=%b, want an=%b d0=%h d1=%h fs=%b",
                     name, anode_select, digit0, digit1, frame_start, an, d0, d1, fs);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        n_vec++;
        if ($countones(anode_select) > 1) begin
            n_bad++;
            $display("FAIL onehot: got anode_select=%b, want at most one bit", anode_select);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset_n = 1'b0;
        write_enable = 1'b0;
        write_pair = 1'b0;
        write_data = 8'h00;
        display_enable = 1'b1;

        add( 1, 1'b1, 1'b0, 8'h3A, 2'b00, 4'h0, 4'h0, 1'b0);
        add( 2, 1'b1, 1'b1, 8'h5C, 2'b00, 4'h0, 4'h0, 1'b0);
        add( 3, 1'b0, 1'b0, 8'h00, 2'b01, 4'h0, 4'h0, 1'b0);
        add( 8, 1'b0, 1'b0, 8'h00, 2'b01, 4'h0, 4'h0, 1'b0);
        add( 9, 1'b0, 1'b0, 8'h00, 2'b00, 4'h0, 4'h0, 1'b0);
        add(11, 1'b0, 1'b0, 8'h00, 2'b10, 4'h0, 4'h0, 1'b0);
        add(16, 1'b0, 1'b0, 8'h00, 2'b10, 4'h0, 4'h0, 1'b1);
        add(17, 1'b0, 1'b0, 8'h00, 2'b00, 4'hA, 4'h3, 1'b0);
        add(19, 1'b0, 1'b0, 8'h00, 2'b01, 4'hA, 4'h3, 1'b0);
        add(20, 1'b1, 1'b1, 8'hFF, 2'b01, 4'hA, 4'h3, 1'b0);
        add(25, 1'b0, 1'b0, 8'h00, 2'b00, 4'hC, 4'h5, 1'b0);
        add(27, 1'b0, 1'b0, 8'h00, 2'b10, 4'hC, 4'h5, 1'b0);
        add(32, 1'b1, 1'b0, 8'h71, 2'b10, 4'hC, 4'h5, 1'b1);
        add(33, 1'b0, 1'b0, 8'h00, 2'b00, 4'hA, 4'h3, 1'b0);
        add(35, 1'b0, 1'b0, 8'h00, 2'b01, 4'hA, 4'h3, 1'b0);
        add(41, 1'b0, 1'b0, 8'h00, 2'b00, 4'hF, 4'hF, 1'b0);
        add(43, 1'b0, 1'b0, 8'h00, 2'b10, 4'hF, 4'hF, 1'b0);
        add(48, 1'b0, 1'b0, 8'h00, 2'b10, 4'hF, 4'hF, 1'b1);
        add(49, 1'b0, 1'b0, 8'h00, 2'b00, 4'h1, 4'h7, 1'b0);
        add(51, 1'b0, 1'b0, 8'h00, 2'b01, 4'h1, 4'h7, 1'b0);

        // Reset state
        @(posedge clock);
        @(posedge clock);
        #1;
        check("reset", 2'b00, 4'h0, 4'h0, 1'b0);
        #1;
        reset_n = 1'b1;

        // Frames: scan timing, commit, write/commit collision
        e = 0;
        foreach (vecs[i]) begin
            while (e < vecs[i].edge_n - 1) begin
                write_enable = 1'b0;
                tick();
                e++;
            end
            write_enable = vecs[i].we;
            write_pair   = vecs[i].wp;
            write_data   = vecs[i].wd;
            tick();
            e++;
            write_enable = 1'b0;
            check($sformatf("edge%0d", vecs[i].edge_n),
                  vecs[i].an, vecs[i].d0, vecs[i].d1, vecs[i].fs);
        end

        // Display hold for 5 cycles mid-slot
        display_enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("hold%0d", k), 2'b00, 4'h1, 4'h7, 1'b0);
        end
        display_enable = 1'b1;
        tick();
        check("resume", 2'b01, 4'h1, 4'h7, 1'b0);
        for (int k = 58; k <= 69; k++) begin
            logic [1:0] ea;
            tick();
            if (k <= 61) ea = 2'b01;
            else if (k <= 63) ea = 2'b00;
            else ea = 2'b10;
            if (k <= 61) check($sformatf("post%0d", k), ea, 4'h1, 4'h7, 1'b0);
            else check($sformatf("post%0d", k), ea, 4'hF, 4'hF, k == 69);
        end

        // Asynchronous reset mid-scan
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst", 2'b00, 4'h0, 4'h0, 1'b0);
        tick();
        reset_n = 1'b1;
        for (int r = 1; r <= 17; r++) begin
            logic [1:0] ea;
            tick();
            if (r >= 3 && r <= 8) ea = 2'b01;
            else if (r >= 11 && r <= 16) ea = 2'b10;
            else ea = 2'b00;
            check($sformatf("rst_r%0d", r), ea, 4'h0, 4'h0, r == 16);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
